// File: rtl/razor_pkg.sv
// ---------------------------------------------------------------------------
// razor_pkg
// Shared types, constants and helpers for the Razor-protected pipeline stages
// of the fully parallel turbo decoder.
//   razor_state_t : recovery FSM states (RUN, RECOVER, FAULT)
//   ERRCNT_W      : width of the saturating error counter output
//   bit_clip()    : signed saturation to a given bit width, common to all
//                   pipe stages so that every stage clips identically
// ---------------------------------------------------------------------------
package razor_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    FAULT   = 2'd2
  } razor_state_t;

  localparam int ERRCNT_W = 8;

  // Saturate a signed value into the signed range of 'width' bits.
  function automatic logic signed [31:0] bit_clip(input logic signed [31:0] value,
                                                  input int                 width);
    logic signed [31:0] hi_v;
    logic signed [31:0] lo_v;
    logic signed [31:0] res_v;
    hi_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo_v = -(32'sd1 <<< (width - 1));
    if (value > hi_v) begin
      res_v = hi_v;
    end else if (value < lo_v) begin
      res_v = lo_v;
    end else begin
      res_v = value;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/razor_shadow_cmp.sv
// ---------------------------------------------------------------------------
// razor_shadow_cmp
// Shadow latch, mismatch comparator and correction mux for the top
// RAZOR_BITS of a Razor-protected register.
// Ports:
//   Clock      in  system clock (latch is transparent while Clock is high)
//   nReset     in  async active-low reset of the shadow latch
//   latch_open in  qualifier for transparency (check phase, no stall, RUN)
//   check_en   in  comparison enable (no stall, RUN); mismatch forced 0 else
//   calc_top   in  late-settling top bits of the combinational result
//   reg_top    in  top bits currently held by the main register
//   fixed_top  out corrected top bits (shadow on mismatch, else reg_top)
//   mismatch   out shadow and main register disagree
// ---------------------------------------------------------------------------
module razor_shadow_cmp #(
  parameter int RAZOR_BITS = 2
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  latch_open,
  input  logic                  check_en,
  input  logic [RAZOR_BITS-1:0] calc_top,
  input  logic [RAZOR_BITS-1:0] reg_top,
  output logic [RAZOR_BITS-1:0] fixed_top,
  output logic                  mismatch
);

  logic                  shadow_en_s;
  logic [RAZOR_BITS-1:0] shadow_r;

  // The shadow samples during the high phase of the check cycle, i.e. later
  // than the main flop, so it holds the value the slow path finally settled to.
  assign shadow_en_s = Clock & latch_open;

  // Level-sensitive shadow storage with async clear.
  always_latch begin
    if (!nReset) begin
      shadow_r <= {RAZOR_BITS{1'b0}};
    end else if (shadow_en_s) begin
      shadow_r <= calc_top;
    end
  end

  assign mismatch  = check_en & (shadow_r != reg_top);
  assign fixed_top = mismatch ? shadow_r : reg_top;

endmodule

// File: rtl/ext_pipe_razor_multi.sv
// ---------------------------------------------------------------------------
// ext_pipe_razor_multi
// Razor-protected extrinsic pipeline stage of the fully parallel turbo
// decoder. Computes
//   be = clip_M( max(eps3, eps4+ba2) - max(eps1, eps2+ba2) )
// and registers it on capture edges (Enable=1). The top RAZOR_BITS of the
// result are re-sampled by a shadow latch during the check phase (Enable=0);
// on disagreement the register is corrected in place, the stage spends one
// capture period in RECOVER, and after MAX_RETRY consecutive erroneous
// periods it locks into FAULT until reset/clear.
// Optional feature: define RAZOR_ERRCNT_EN to build the saturating error
// counter behind Err_Count; otherwise Err_Count is tied to zero.
// Ports:
//   Clock          in  system clock
//   nReset         in  async active-low reset
//   nClear         in  async active-low clear (same effect as nReset)
//   Enable         in  1 = capture phase, 0 = check phase
//   Error_previous in  stall from the upstream stage
//   ba2            in  N-bit signed a-priori term
//   epsilon        in  4 x (M+1)-bit signed terms, indices [4:1]
//   be_DFF         out M-bit signed registered extrinsic value
//   Error_current  out stall to the downstream stage
//   Fault          out sticky fault flag
//   Err_Count      out saturating count of detected errors
// ---------------------------------------------------------------------------
module ext_pipe_razor_multi
  import razor_pkg::*;
#(
  parameter int N          = 5,
  parameter int M          = 6,
  parameter int RAZOR_BITS = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                nClear,
  input  logic                Enable,
  input  logic                Error_previous,
  input  logic [N-1:0]        ba2,
  input  logic [4:1][M:0]     epsilon,
  output logic [M-1:0]        be_DFF,
  output logic                Error_current,
  output logic                Fault,
  output logic [ERRCNT_W-1:0] Err_Count
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  // -------------------------------------------------------------------------
  // Reset / stall
  // -------------------------------------------------------------------------
  logic rst_all_n_s;
  logic stall_s;

  assign rst_all_n_s = nReset & nClear;
  assign stall_s     = Error_previous;

  // -------------------------------------------------------------------------
  // Combinational datapath (M+2 bit intermediate sums cannot overflow)
  // -------------------------------------------------------------------------
  logic signed [N-1:0] ba2_s;
  logic signed [M:0]   eps1_s;
  logic signed [M:0]   eps2_s;
  logic signed [M:0]   eps3_s;
  logic signed [M:0]   eps4_s;
  logic signed [M+1:0] ba2_x_s;
  logic signed [M+1:0] eps1_x_s;
  logic signed [M+1:0] eps3_x_s;
  logic signed [M+1:0] e2b_s;
  logic signed [M+1:0] e4b_s;
  logic signed [M+1:0] a_s;
  logic signed [M+1:0] b_s;
  logic signed [M+2:0] d_s;
  logic [M-1:0]        be_calc_s;

  assign ba2_s  = ba2;
  assign eps1_s = epsilon[1];
  assign eps2_s = epsilon[2];
  assign eps3_s = epsilon[3];
  assign eps4_s = epsilon[4];

  assign ba2_x_s  = (M+2)'(ba2_s);
  assign eps1_x_s = (M+2)'(eps1_s);
  assign eps3_x_s = (M+2)'(eps3_s);
  assign e2b_s    = (M+2)'(eps2_s) + ba2_x_s;
  assign e4b_s    = (M+2)'(eps4_s) + ba2_x_s;

  assign a_s = (eps1_x_s > e2b_s) ? eps1_x_s : e2b_s;
  assign b_s = (eps3_x_s > e4b_s) ? eps3_x_s : e4b_s;
  assign d_s = (M+3)'(b_s) - (M+3)'(a_s);

  assign be_calc_s = M'(bit_clip(32'(d_s), M));

  // -------------------------------------------------------------------------
  // State and main register
  // -------------------------------------------------------------------------
  razor_state_t        state_r;
  logic [M-1:0]        be_r;
  logic [RW-1:0]       retry_r;
  logic                fault_r;

  logic                run_s;
  logic                latch_open_s;
  logic                check_en_s;
  logic                mismatch_s;
  logic [RAZOR_BITS-1:0] fixed_top_s;
  logic [M-1:0]        be_fix_s;
  logic                take_err_s;
  logic                last_try_s;

  assign run_s        = (state_r == RUN);
  assign check_en_s   = ~stall_s & run_s;
  assign latch_open_s = ~Enable & check_en_s;

  razor_shadow_cmp #(
    .RAZOR_BITS (RAZOR_BITS)
  ) u_shadow_cmp (
    .Clock      (Clock),
    .nReset     (rst_all_n_s),
    .latch_open (latch_open_s),
    .check_en   (check_en_s),
    .calc_top   (be_calc_s[M-1 -: RAZOR_BITS]),
    .reg_top    (be_r[M-1 -: RAZOR_BITS]),
    .fixed_top  (fixed_top_s),
    .mismatch   (mismatch_s)
  );

  // Corrected register image: shadow replaces the top bits, lower bits kept.
  always_comb begin
    be_fix_s                     = be_r;
    be_fix_s[M-1 -: RAZOR_BITS]  = fixed_top_s;
  end

  // mismatch_s is already masked by stall and non-RUN states.
  assign take_err_s = ~Enable & mismatch_s;
  assign last_try_s = (({1'b0, retry_r} + {{RW{1'b0}}, 1'b1}) == (RW+1)'(MAX_RETRY));

  // Recovery FSM together with the main register, retry counter and fault flag.
  always_ff @(posedge Clock or negedge rst_all_n_s) begin
    if (!rst_all_n_s) begin
      state_r <= RUN;
      be_r    <= {M{1'b0}};
      retry_r <= {RW{1'b0}};
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (!stall_s) begin
            if (Enable) begin
              be_r <= be_calc_s;
            end else if (take_err_s) begin
              be_r    <= be_fix_s;
              retry_r <= retry_r + RW'(1'b1);
              if (last_try_s) begin
                state_r <= FAULT;
                fault_r <= 1'b1;
              end else begin
                state_r <= RECOVER;
              end
            end else begin
              retry_r <= {RW{1'b0}};
            end
          end
        end
        RECOVER: begin
          // The capture edge after a correction is spent re-aligning, not capturing.
          if (!stall_s && Enable) begin
            state_r <= RUN;
          end
        end
        FAULT: begin
          fault_r <= 1'b1;
        end
        default: begin
          state_r <= FAULT;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign be_DFF        = be_r;
  assign Fault         = fault_r;
  assign Error_current = mismatch_s | (state_r == RECOVER) | (state_r == FAULT);

  // -------------------------------------------------------------------------
  // Optional saturating error counter
  // -------------------------------------------------------------------------
`ifdef RAZOR_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_r;

  // Count every RUN->RECOVER / RUN->FAULT transition, saturating at all-ones.
  always_ff @(posedge Clock or negedge rst_all_n_s) begin
    if (!rst_all_n_s) begin
      err_cnt_r <= {ERRCNT_W{1'b0}};
    end else if (take_err_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERRCNT_W'(1'b1);
    end
  end

  assign Err_Count = err_cnt_r;
`else
  assign Err_Count = {ERRCNT_W{1'b0}};
`endif

endmodule

// File: doc/ext_pipe_razor_multi.md
Name: ext_pipe_razor_multi

Overview:
- Parametrised successor of the single-bit Razor extrinsic pipeline stage in the fully parallel turbo decoder.
- Computes be = clip(max(eps3, eps4+ba2) - max(eps1, eps2+ba2)) and registers it behind Enable/Error_previous gating.
- Protects the top RAZOR_BITS of the result with shadow latches.
- Adds in-place error correction via a recovery FSM, consecutive-error tracking and a sticky fault flag.

Parameters:
- N, 5, width of signed ba2.
- M, 6, width of registered output be_DFF; each epsilon is M+1 bits signed.
- RAZOR_BITS, 2, number of MSBs of be monitored by shadow latches (1..M).
- MAX_RETRY, 3, consecutive erroneous capture periods before FAULT (>=1).

Ports:
- Clock  input  1  system clock.
- nReset  input  1  asynchronous active-low reset.
- nClear  input  1  asynchronous active-low clear; same effect as nReset.
- Enable  input  1  capture phase when 1; check phase when 0.
- Error_previous  input  1  stall from the upstream stage.
- ba2  input  N  signed a-priori term.
- epsilon  input  4x(M+1)  signed packed, indices [4:1].
- be_DFF  output  M  signed registered extrinsic output.
- Error_current  output  1  stall to the downstream stage.
- Fault  output  1  sticky fault indication.
- Err_Count  output  8  saturating error count (see Optional Feature).

Behaviour:
- Datapath (combinational):
  - e2b = eps2+ba2 and e4b = eps4+ba2, both M+2 bits signed.
  - A = signed max(eps1, e2b); B = signed max(eps3, e4b).
  - D = B-A, M+3 bits signed.
  - be_calc = D saturated to the signed M-bit range [-2^(M-1), 2^(M-1)-1].
- Stall: stall = Error_previous.
- Main register:
  - Async reset/clear: be_DFF=0.
  - At posedge Clock with Enable=1, !stall and state RUN: be_DFF <= be_calc.
- Shadow latch (RAZOR_BITS wide):
  - Transparent while Clock=1 && Enable=0 && !stall && state==RUN; captures be_calc[M-1 -: RAZOR_BITS].
  - Reset/clear value is 0.
- Mismatch:
  - mismatch = (shadow != be_DFF[M-1 -: RAZOR_BITS]).
  - Masked to 0 when stall=1 or state!=RUN.
- FSM states: RUN, RECOVER, FAULT. Reset state is RUN. All transitions happen at posedge Clock.
- RUN:
  - Posedge with Enable=0, !stall and mismatch:
    - be_DFF[M-1 -: RAZOR_BITS] <= shadow; lower bits are kept.
    - retry_cnt++.
    - Go to FAULT if retry_cnt+1 == MAX_RETRY, else go to RECOVER.
  - Posedge with Enable=0, !stall and no mismatch: retry_cnt <= 0.
- RECOVER:
  - Lasts exactly one capture period; be_DFF holds.
  - Next posedge with Enable=1 returns to RUN without capturing.
  - stall in RECOVER: the FSM holds.
- FAULT:
  - be_DFF holds, Fault=1, Error_current=1.
  - Exited only by nReset or nClear.
- Error_current = mismatch | (state==RECOVER) | (state==FAULT).
  - The mismatch term is combinational, so the downstream stage sees the error within the check cycle.
- Latency: one capture edge from inputs to be_DFF; correction costs one extra capture period.
- Boundary conditions:
  - Error_previous and mismatch together: stall wins; no correction, no count.
  - Reset or clear mid-RECOVER: returns to RUN with all registers cleared.
  - D exactly at a saturation bound passes unchanged.

Optional Feature:
- Macro RAZOR_ERRCNT_EN.
- Defined:
  - Err_Count increments by 1 on every RUN->RECOVER or RUN->FAULT transition.
  - Saturates at 255.
  - Cleared by nReset or nClear.
- Undefined: Err_Count is tied to 0 and no counter flops are built.

Decomposition:
- Shared package razor_pkg:
  - typedef razor_state_t {RUN, RECOVER, FAULT}.
  - ERRCNT_W=8.
  - Saturating-clip function signature shared with the other pipe stages.
- One natural sub-module: razor_shadow_cmp, holding the shadow latch, the mismatch comparator and the correction mux, parametrised by RAZOR_BITS.
- Reuse the existing BitClip for saturation.

Test Plan (M=6, N=5):
- Nominal: eps1=5, eps2=3, eps3=10, eps4=-2, ba2=4, Enable=1 edge -> be_DFF=3; Error_current=0.
- Saturation, positive: eps3=60, eps1=-60, eps2=-60, eps4=-60, ba2=0 -> be_DFF=31. Negative mirror -> be_DFF=-32.
- Single timing error:
  - Stimulus: capture be=3, then change inputs during the check phase so be_calc=-29, making the top 2 bits differ.
  - Response: Error_current=1 in that check cycle; next edge gives be_DFF top bits = shadow; one RECOVER period; back to RUN; Err_Count=1 with RAZOR_ERRCNT_EN.
- Stall priority: Error_previous=1 during a mismatching check phase -> Error_current=0 from mismatch; be_DFF unchanged; FSM stays in RUN.
- Fault: MAX_RETRY=3 consecutive erroneous periods -> Fault=1, Error_current=1, be_DFF frozen; nClear pulse -> RUN, be_DFF=0, Fault=0.
- Reset mid-RECOVER: nReset pulse during RECOVER -> state RUN, be_DFF=0, shadow 0, retry_cnt 0, Err_Count 0.
